// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate-generator pipeline stage:
// format-select codes and the registered output bundle width.
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_Z     = 3'b101,
    IMM_SHAMT = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_src_e;

  // Bundle is {illegal, target, imm_ext, pc}.
  function automatic int bundle_w(input int xlen);
    return 3 * xlen + 1;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// Pure combinational immediate decode for every RV32I/RV64I format plus
// CSR zimm and shift-amount forms; flags reserved format and bad shamt.
module imm_decode_comb
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_imm_src,
  output logic [XLEN-1:0] o_imm_ext,
  output logic            o_illegal
);

  // Opcode bits never carry immediate data.
  logic w_unused_opcode;
  assign w_unused_opcode = ^i_instr[6:0];

  always_comb begin
    o_imm_ext = '0;
    o_illegal = 1'b0;
    case (i_imm_src)
      IMM_I: o_imm_ext = XLEN'($signed({{20{i_instr[31]}}, i_instr[31:20]}));
      IMM_S: o_imm_ext = XLEN'($signed({{20{i_instr[31]}}, i_instr[31:25],
                                        i_instr[11:7]}));
      IMM_B: o_imm_ext = XLEN'($signed({{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                        i_instr[30:25], i_instr[11:8], 1'b0}));
      IMM_U: o_imm_ext = XLEN'($signed({i_instr[31:12], 12'b0}));
      IMM_J: o_imm_ext = XLEN'($signed({{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                        i_instr[20], i_instr[30:21], 1'b0}));
      IMM_Z: o_imm_ext = XLEN'(i_instr[19:15]);
      IMM_SHAMT: begin
        // RV32 shifts only have 5 shamt bits; bit 25 set is an illegal encoding.
        if (XLEN == 64) begin
          o_imm_ext = XLEN'(i_instr[25:20]);
        end else begin
          o_imm_ext = XLEN'(i_instr[24:20]);
          o_illegal = i_instr[25];
        end
      end
      IMM_RSVD: o_illegal = 1'b1;
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// ID-stage immediate generator: decode + PC-relative target, registered
// behind a valid/ready boundary with an optional two-entry skid buffer.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] instr,
  input  logic [2:0]      imm_src,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] imm_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam int BW = bundle_w(XLEN);

  // Handshake: a beat moves on a side only in a cycle where both valid and
  // ready are high at the rising edge; a held output never changes until taken.
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic [XLEN-1:0] w_target;
  logic [BW-1:0]   w_in_bundle;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic [BW-1:0]   r_out;
  logic            r_out_valid;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .i_instr   (instr[31:0]),
    .i_imm_src (imm_src),
    .o_imm_ext (w_imm),
    .o_illegal (w_illegal)
  );

  assign w_target    = pc + w_imm;
  assign w_in_bundle = {w_illegal, w_target, w_imm, pc};
  assign w_in_xfer   = in_valid & in_ready;
  assign w_out_xfer  = r_out_valid & out_ready;

  assign out_valid = r_out_valid;
  assign {out_illegal, imm_target, imm_ext, out_pc} = r_out;

  generate
    if (SKID != 0) begin : g_skid
      logic [BW-1:0] r_skid;
      logic          r_skid_valid;

      assign in_ready = !r_skid_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out        <= '0;
          r_out_valid  <= 1'b0;
          r_skid       <= '0;
          r_skid_valid <= 1'b0;
        end else if (flush) begin
          r_out_valid  <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (w_out_xfer || !r_out_valid) begin
          // Output slot frees this edge: skid entry first to keep FIFO order.
          if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
          end else if (w_in_xfer) begin
            r_out       <= w_in_bundle;
            r_out_valid <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
          end
        end else if (w_in_xfer) begin
          r_skid       <= w_in_bundle;
          r_skid_valid <= 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready = !r_out_valid | out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out       <= '0;
          r_out_valid <= 1'b0;
        end else if (flush) begin
          r_out_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_out       <= w_in_bundle;
          r_out_valid <= 1'b1;
        end else if (w_out_xfer) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe (XLEN=32, SKID=1): directed formats,
// backpressure, flush, async reset and randomized traffic vs a FIFO model.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_ext;
  logic [31:0] imm_target;
  logic [31:0] out_pc;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dut_deliv = 0;

  logic [96:0] exp_q[$];

  imm_gen_pipe #(.XLEN(32), .ILEN(32), .SKID(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .imm_src     (imm_src),
    .pc          (pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .imm_ext     (imm_ext),
    .imm_target  (imm_target),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [96:0] ref_bundle(input logic [31:0] ins, input logic [2:0] src,
                                             input logic [31:0] p);
    longint v;
    longint t;
    logic   ill;
    logic [31:0] imm;
    logic [31:0] tgt;
    v   = 0;
    ill = 1'b0;
    case (src)
      3'd0: begin v = ins[31:20]; if (v >= 2048) v -= 4096; end
      3'd1: begin v = ins[31:25] * 32 + ins[11:7]; if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin v = longint'(ins[31:12]) * 4096; if (v >= 64'sd2147483648) v -= 64'sd4294967296; end
      3'd4: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 + ins[20] * 2048
            + ins[30:21] * 2;
        if (v >= 1048576) v -= 2097152;
      end
      3'd5: v = ins[19:15];
      3'd6: begin v = ins[24:20]; ill = ins[25]; end
      default: begin v = 0; ill = 1'b1; end
    endcase
    imm = v[31:0];
    t   = (longint'(p) + v) % 64'sd4294967296;
    if (t < 0) t += 64'sd4294967296;
    tgt = t[31:0];
    return {ill, tgt, imm, p};
  endfunction

  // ---------------- driver + scoreboard ----------------
  // Entered at posedge+1; checks outputs registered by the previous edge.
  task automatic drive(input logic iv, input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] p, input logic ordy, input logic fl);
    logic exp_rdy, exp_ov, in_x, out_x;
    logic [96:0] got;
    in_valid  = iv;
    instr     = ins;
    imm_src   = src;
    pc        = p;
    out_ready = ordy;
    flush     = fl;
    exp_rdy = (exp_q.size() < 2);
    exp_ov  = (exp_q.size() > 0);
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_rdy);
    end
    n_checks++;
    if (out_valid !== exp_ov) begin
      n_fail++;
      $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_ov);
    end
    if (exp_ov) begin
      got = {out_illegal, imm_target, imm_ext, out_pc};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL sb_bundle t=%0t got=%h exp=%h", $time, got, exp_q[0]);
      end
    end
    if (out_valid === 1'b1 && ordy) n_dut_deliv++;
    in_x  = iv && exp_rdy;
    out_x = exp_ov && ordy;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_x) void'(exp_q.pop_front());
      if (in_x) exp_q.push_back(ref_bundle(ins, src, p));
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'h0, 3'd0, 32'h0, ordy, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if ({imm_ext, imm_target, out_pc} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", imm_ext, imm_target, out_pc);
    end
    n_checks++;
    if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", out_illegal); end
  endtask

  task automatic test_formats;
    logic [31:0] t_ins [7] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7,
                               32'h00800093, 32'hFFFFFFFF, 32'h02000093};
    logic [2:0]  t_src [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd7, 3'd6};
    logic [31:0] t_pc  [7] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'hFFFFFFFC,
                               32'h200, 32'h300};
    logic [31:0] t_imm [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                               32'h00000008, 32'h0, 32'h0};
    logic [31:0] t_tgt [7] = '{32'h000000FF, 32'h000000FC, 32'h000000F8, 32'h12345100,
                               32'h00000004, 32'h200, 32'h300};
    logic        t_ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, t_ins[i], t_src[i], t_pc[i], 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || imm_ext !== t_imm[i]) begin
        n_fail++;
        $display("FAIL fmt%0d_imm valid=%b got=%h exp=%h", i, out_valid, imm_ext, t_imm[i]);
      end
      n_checks++;
      if (imm_target !== t_tgt[i]) begin
        n_fail++;
        $display("FAIL fmt%0d_target got=%h exp=%h", i, imm_target, t_tgt[i]);
      end
      n_checks++;
      if (out_illegal !== t_ill[i]) begin
        n_fail++;
        $display("FAIL fmt%0d_illegal got=%b exp=%b", i, out_illegal, t_ill[i]);
      end
    end
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic test_backpressure;
    int base;
    drive(1'b1, 32'hAAA00093, 3'd0, 32'h1000, 1'b0, 1'b0);
    drive(1'b1, 32'hBBB00093, 3'd0, 32'h2000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hCCC00093, 3'd0, 32'h3000, 1'b0, 1'b0);
      n_checks++;
      if (in_ready !== 1'b0 || out_pc !== 32'h1000) begin
        n_fail++;
        $display("FAIL bp_hold in_ready=%b out_pc=%h exp 0/00001000", in_ready, out_pc);
      end
    end
    base = n_dut_deliv;
    drive(1'b1, 32'hCCC00093, 3'd0, 32'h3000, 1'b1, 1'b0);  // A out, C refused
    drive(1'b1, 32'hCCC00093, 3'd0, 32'h3000, 1'b1, 1'b0);  // B out, C taken
    idle(1'b1);                                              // C out
    idle(1'b1);
    n_checks++;
    if (n_dut_deliv - base !== 3) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=3", n_dut_deliv - base);
    end
  endtask

  task automatic test_flush;
    int base;
    drive(1'b1, 32'h11100093, 3'd0, 32'h4000, 1'b0, 1'b0);
    drive(1'b1, 32'h22200093, 3'd0, 32'h5000, 1'b0, 1'b0);
    drive(1'b1, 32'h33300093, 3'd0, 32'h6000, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    base = n_dut_deliv;
    for (int i = 0; i < 3; i++) idle(1'b1);
    n_checks++;
    if (n_dut_deliv - base !== 0) begin
      n_fail++;
      $display("FAIL flush_leak got=%0d exp=0", n_dut_deliv - base);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'h7FF00093, 3'd0, 32'h8000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_ctrl out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    n_checks++;
    if ({out_illegal, imm_ext, imm_target, out_pc} !== 97'h0) begin
      n_fail++;
      $display("FAIL arst_data got=%h/%h/%h exp=0", imm_ext, imm_target, out_pc);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) idle(1'b0);
    drive(1'b1, 32'h00500093, 3'd0, 32'h9000, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || imm_target !== 32'h9005) begin
      n_fail++;
      $display("FAIL arst_resume valid=%b target=%h exp 1/00009005", out_valid, imm_target);
    end
    idle(1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    imm_src   = '0;
    pc        = '0;
    out_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
